// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl - sequencing controller for the shared iterative multiplier /
// divider of the M-extension execute path. Takes one M-type op at a time,
// hands magnitudes to the arithmetic units, fixes up sign and RISC-V
// divide corner cases, and returns a one-cycle writeback pulse.
//
// Build option: define MULDIV_FAST_ZERO_EN to resolve divide-by-zero and
// signed-overflow divides in the controller itself (IDLE -> RESP) without
// ever raising div_req_o. Without it every divide goes through the divider
// and the same override is applied when div_ready_i returns.
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [2:0]        issue_funct3_i,
    input  logic [XLEN-1:0]   issue_op1_i,
    input  logic [XLEN-1:0]   issue_op2_i,
    input  logic [4:0]        issue_rd_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              mul_req_o,
    output logic [XLEN-1:0]   mul_a_o,
    output logic [XLEN-1:0]   mul_b_o,
    input  logic              mul_ready_i,
    input  logic [2*XLEN-1:0] mul_result_i,
    output logic              div_req_o,
    output logic [XLEN-1:0]   div_a_o,
    output logic [XLEN-1:0]   div_b_o,
    output logic              div_is_q_o,
    input  logic              div_ready_i,
    input  logic [XLEN-1:0]   div_result_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_WAIT = 3'd1,
        ST_DIV_WAIT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // Two's complement negate at operand width.
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1'b1);
    endfunction

    // Two's complement negate at product width.
    function automatic logic [2*XLEN-1:0] neg_w(input logic [2*XLEN-1:0] v);
        return ~v + (2*XLEN)'(1'b1);
    endfunction

    // RISC-V divide corner cases override whatever the divider produced.
    function automatic logic [XLEN-1:0] div_fix(
        input logic [2:0]      f,
        input logic            zero,
        input logic            ovf,
        input logic [XLEN-1:0] op1,
        input logic [XLEN-1:0] res
    );
        logic [XLEN-1:0] r;
        if (zero) begin
            r = f[1] ? op1 : {XLEN{1'b1}};
        end else if (ovf) begin
            r = f[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            r = res;
        end
        return r;
    endfunction

    state_t            state_r;
    logic              ready_r;
    logic              mul_req_r;
    logic              div_req_r;
    logic              div_is_q_r;
    logic [XLEN-1:0]   mul_a_r;
    logic [XLEN-1:0]   mul_b_r;
    logic [XLEN-1:0]   div_a_r;
    logic [XLEN-1:0]   div_b_r;
    logic              wb_valid_r;
    logic [4:0]        wb_rd_r;
    logic [XLEN-1:0]   wb_data_r;
    logic [2:0]        funct3_r;
    logic [4:0]        rd_r;
    logic              op1_neg_r;
    logic              op2_neg_r;
    logic              div_zero_r;
    logic              ovf_r;
    logic [XLEN-1:0]   op1_raw_r;

    logic              accept_s;
    logic              is_div_s;
    logic              op1_signed_s;
    logic              op2_signed_s;
    logic              op1_neg_s;
    logic              op2_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic              div_zero_s;
    logic              ovf_s;
    logic              fast_s;
    logic [2*XLEN-1:0] prod_adj_s;
    logic [XLEN-1:0]   mul_res_s;
    logic [XLEN-1:0]   div_sgn_s;
    logic [XLEN-1:0]   div_res_s;

    // Decode the presented op: signedness, magnitudes and corner-case flags.
    always_comb begin
        op1_signed_s = 1'b0;
        op2_signed_s = 1'b0;
        case (issue_funct3_i)
            3'd1, 3'd4, 3'd6: begin
                op1_signed_s = 1'b1;
                op2_signed_s = 1'b1;
            end
            3'd2: begin
                op1_signed_s = 1'b1;
                op2_signed_s = 1'b0;
            end
            default: begin
                op1_signed_s = 1'b0;
                op2_signed_s = 1'b0;
            end
        endcase
        is_div_s   = issue_funct3_i[2];
        accept_s   = issue_valid_i & ready_r & ~flush_i;
        op1_neg_s  = op1_signed_s & issue_op1_i[XLEN-1];
        op2_neg_s  = op2_signed_s & issue_op2_i[XLEN-1];
        a_mag_s    = op1_neg_s ? neg_x(issue_op1_i) : issue_op1_i;
        b_mag_s    = op2_neg_s ? neg_x(issue_op2_i) : issue_op2_i;
        div_zero_s = (issue_op2_i == {XLEN{1'b0}});
        ovf_s      = op1_signed_s & is_div_s
                   & (issue_op1_i == {1'b1, {(XLEN-1){1'b0}}})
                   & (issue_op2_i == {XLEN{1'b1}});
`ifdef MULDIV_FAST_ZERO_EN
        fast_s     = is_div_s & (div_zero_s | ovf_s);
`else
        fast_s     = 1'b0;
`endif
    end

    // Sign-correct the unit results for the op held in the registers.
    always_comb begin
        prod_adj_s = (op1_neg_r ^ op2_neg_r) ? neg_w(mul_result_i) : mul_result_i;
        if (funct3_r == 3'd0) begin
            mul_res_s = mul_result_i[XLEN-1:0];
        end else begin
            mul_res_s = prod_adj_s[2*XLEN-1:XLEN];
        end
        if (funct3_r[1]) begin
            div_sgn_s = op1_neg_r ? neg_x(div_result_i) : div_result_i;
        end else begin
            div_sgn_s = (op1_neg_r ^ op2_neg_r) ? neg_x(div_result_i) : div_result_i;
        end
        div_res_s = div_fix(funct3_r, div_zero_r, ovf_r, op1_raw_r, div_sgn_s);
    end

    // Control FSM with registered handshakes, operands and writeback.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            ready_r    <= 1'b0;
            mul_req_r  <= 1'b0;
            div_req_r  <= 1'b0;
            div_is_q_r <= 1'b0;
            mul_a_r    <= {XLEN{1'b0}};
            mul_b_r    <= {XLEN{1'b0}};
            div_a_r    <= {XLEN{1'b0}};
            div_b_r    <= {XLEN{1'b0}};
            wb_valid_r <= 1'b0;
            wb_rd_r    <= 5'd0;
            wb_data_r  <= {XLEN{1'b0}};
            funct3_r   <= 3'd0;
            rd_r       <= 5'd0;
            op1_neg_r  <= 1'b0;
            op2_neg_r  <= 1'b0;
            div_zero_r <= 1'b0;
            ovf_r      <= 1'b0;
            op1_raw_r  <= {XLEN{1'b0}};
        end else begin
            wb_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b1;
                    if (accept_s) begin
                        ready_r    <= 1'b0;
                        funct3_r   <= issue_funct3_i;
                        rd_r       <= issue_rd_i;
                        op1_neg_r  <= op1_neg_s;
                        op2_neg_r  <= op2_neg_s;
                        div_zero_r <= div_zero_s;
                        ovf_r      <= ovf_s;
                        op1_raw_r  <= issue_op1_i;
                        if (fast_s) begin
                            state_r    <= ST_RESP;
                            wb_valid_r <= 1'b1;
                            wb_rd_r    <= issue_rd_i;
                            wb_data_r  <= div_fix(issue_funct3_i, div_zero_s, ovf_s,
                                                  issue_op1_i, {XLEN{1'b0}});
                        end else if (is_div_s) begin
                            state_r    <= ST_DIV_WAIT;
                            div_req_r  <= 1'b1;
                            div_a_r    <= a_mag_s;
                            div_b_r    <= b_mag_s;
                            div_is_q_r <= ~issue_funct3_i[1];
                        end else begin
                            state_r   <= ST_MUL_WAIT;
                            mul_req_r <= 1'b1;
                            mul_a_r   <= a_mag_s;
                            mul_b_r   <= b_mag_s;
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    if (mul_ready_i) begin
                        mul_req_r <= 1'b0;
                        if (flush_i) begin
                            state_r <= ST_IDLE;
                            ready_r <= 1'b1;
                        end else begin
                            state_r    <= ST_RESP;
                            wb_valid_r <= 1'b1;
                            wb_rd_r    <= rd_r;
                            wb_data_r  <= mul_res_s;
                        end
                    end else if (flush_i) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_ready_i) begin
                        div_req_r <= 1'b0;
                        if (flush_i) begin
                            state_r <= ST_IDLE;
                            ready_r <= 1'b1;
                        end else begin
                            state_r    <= ST_RESP;
                            wb_valid_r <= 1'b1;
                            wb_rd_r    <= rd_r;
                            wb_data_r  <= div_res_s;
                        end
                    end else if (flush_i) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The unit still owns the request; wait for it, then drop the result.
                    if ((mul_req_r & mul_ready_i) | (div_req_r & div_ready_i)) begin
                        mul_req_r <= 1'b0;
                        div_req_r <= 1'b0;
                        state_r   <= ST_IDLE;
                        ready_r   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    ready_r   <= 1'b0;
                    mul_req_r <= 1'b0;
                    div_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Stall depends on this cycle's flush/valid, so it is formed from state here.
    always_comb begin
        stall_o = rst_i & ~flush_i &
                  (((state_r == ST_IDLE)  & issue_valid_i) |
                   (state_r == ST_MUL_WAIT) |
                   (state_r == ST_DIV_WAIT) |
                   ((state_r == ST_DRAIN) & issue_valid_i));
    end

    assign issue_ready_o = ready_r;
    assign mul_req_o     = mul_req_r;
    assign mul_a_o       = mul_a_r;
    assign mul_b_o       = mul_b_r;
    assign div_req_o     = div_req_r;
    assign div_a_o       = div_a_r;
    assign div_b_o       = div_b_r;
    assign div_is_q_o    = div_is_q_r;
    assign wb_valid_o    = wb_valid_r & ~flush_i;
    assign wb_rd_o       = wb_rd_r;
    assign wb_data_o     = wb_data_r;

endmodule
